// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - start/busy/valid handshake and operand/result bundle for seq_divider
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic             kill_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             valid_o;
    logic [WIDTH-1:0] res_o;

    modport master (
        output start_i, kill_i, op_i, a_i, b_i,
        input  busy_o, valid_o, res_o
    );

    modport slave (
        input  start_i, kill_i, op_i, a_i, b_i,
        output busy_o, valid_o, res_o
    );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
// Optional DIV_EARLY_OUT_EN: resolves |a| < |b| on the start edge with latency 1.
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave dif
);
    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_e;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             valid_q, valid_d;

    logic             in_signed, a_neg, b_neg, b_zero, ovf, early;
    logic [WIDTH-1:0] a_mag, b_mag, quo_fin, rem_fin;
    logic [WIDTH+1:0] shifted, trial;

    always_comb begin
        in_signed = ~dif.op_i[0];
        a_neg     = in_signed & dif.a_i[WIDTH-1];
        b_neg     = in_signed & dif.b_i[WIDTH-1];
        a_mag     = a_neg ? -dif.a_i : dif.a_i;
        b_mag     = b_neg ? -dif.b_i : dif.b_i;
        b_zero    = (dif.b_i == '0);
        ovf       = in_signed & (dif.a_i == MIN_NEG) & (dif.b_i == '1);
`ifdef DIV_EARLY_OUT_EN
        early     = (a_mag < b_mag);
`else
        early     = 1'b0;
`endif
        // rem_q < div_q always holds, so one extra bit is enough to read the trial sign
        shifted   = {rem_q, quo_q[WIDTH-1]};
        trial     = shifted - {2'b00, div_q};
        quo_fin   = neg_quo_q ? -quo_q : quo_q;
        rem_fin   = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        div_d     = div_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        res_d     = res_q;
        valid_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (dif.start_i && !dif.kill_i) begin
                    if (b_zero) begin
                        res_d   = dif.op_i[1] ? dif.a_i : '1;
                        valid_d = 1'b1;
                    end else if (ovf) begin
                        res_d   = dif.op_i[1] ? '0 : MIN_NEG;
                        valid_d = 1'b1;
                    end else if (early) begin
                        res_d   = dif.op_i[1] ? dif.a_i : '0;
                        valid_d = 1'b1;
                    end else begin
                        op_d      = dif.op_i;
                        div_d     = b_mag;
                        quo_d     = a_mag;
                        rem_d     = '0;
                        cnt_d     = '0;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                if (dif.kill_i) begin
                    state_d = IDLE;
                end else begin
                    if (!trial[WIDTH+1]) begin
                        rem_d = trial[WIDTH:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[WIDTH:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH-1)) begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
                if (!dif.kill_i) begin
                    res_d   = op_q[1] ? rem_fin : quo_fin;
                    valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            div_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            res_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            div_q     <= div_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            res_q     <= res_d;
            valid_q   <= valid_d;
        end
    end

    assign dif.busy_o  = (state_q != IDLE);
    assign dif.valid_o = valid_q;
    assign dif.res_o   = res_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - table-driven self-checking bench for seq_divider
module tb_seq_divider;
    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY_BUILD = 1'b1;
`else
    localparam bit EARLY_BUILD = 1'b0;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          special;
        bit          early;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(32)) dif ();
    seq_divider #(.WIDTH(32), .CNT_W(5)) dut (.clk(clk), .rst_n(rst_n), .dif(dif));

    int tests = 0;
    int fails = 0;
    int viol = 0;
    logic valid_prev = 1'b0;
    vec_t vecs[16];

    always @(negedge clk) begin
        if (dif.valid_o && dif.busy_o) viol++;
        if (dif.valid_o && valid_prev) viol++;
        valid_prev = dif.valid_o;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(output logic [31:0] res, output int lat, output int busy_n);
        lat = 1;
        busy_n = 0;
        while (!dif.valid_o && lat < 100) begin
            if (dif.busy_o) busy_n++;
            @(negedge clk);
            lat++;
        end
        res = dif.res_o;
        if (!dif.valid_o) lat = -1;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int busy_n);
        @(negedge clk);
        dif.start_i = 1'b1;
        dif.op_i = op;
        dif.a_i = a;
        dif.b_i = b;
        @(negedge clk);
        dif.start_i = 1'b0;
        wait_valid(res, lat, busy_n);
    endtask

    initial begin
        logic [31:0] res;
        int lat, busy_n, exp_lat, seen;

        vecs[0]  = '{OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 0};
        vecs[1]  = '{OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, 0};
        vecs[2]  = '{OP_REMU, 32'hFFFFFFF9, 32'd2,        32'h00000001, 0, 0};
        vecs[3]  = '{OP_DIVU, 32'd6,        32'd3,        32'h00000002, 0, 0};
        vecs[4]  = '{OP_DIV,  32'd6,        32'd0,        32'hFFFFFFFF, 1, 0};
        vecs[5]  = '{OP_DIVU, 32'd6,        32'd0,        32'hFFFFFFFF, 1, 0};
        vecs[6]  = '{OP_REM,  32'd6,        32'd0,        32'h00000006, 1, 0};
        vecs[7]  = '{OP_REMU, 32'd6,        32'd0,        32'h00000006, 1, 0};
        vecs[8]  = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0};
        vecs[9]  = '{OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 0};
        vecs[10] = '{OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0, 1};
        vecs[11] = '{OP_DIVU, 32'd3,        32'd10,       32'h00000000, 0, 1};
        vecs[12] = '{OP_REM,  32'd3,        32'hFFFFFFF6, 32'h00000003, 0, 1};
        vecs[13] = '{OP_DIV,  32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 0, 0};
        vecs[14] = '{OP_REM,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 0, 0};
        vecs[15] = '{OP_REMU, 32'd100,      32'd7,        32'h00000002, 0, 0};

        dif.start_i = 1'b0;
        dif.kill_i = 1'b0;
        dif.op_i = 2'b00;
        dif.a_i = '0;
        dif.b_i = '0;

        #2;
        check("reset busy", {31'b0, dif.busy_o}, 32'd0);
        check("reset valid", {31'b0, dif.valid_o}, 32'd0);
        check("reset res", dif.res_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, busy_n);
            exp_lat = (vecs[i].special || (EARLY_BUILD && vecs[i].early)) ? 1 : 34;
            check($sformatf("vec%0d res", i), res, vecs[i].exp);
            check($sformatf("vec%0d latency", i), lat, exp_lat);
            check($sformatf("vec%0d busy cycles", i), busy_n, exp_lat - 1);
        end

        // kill during CALC, then start+kill together in IDLE
        run_op(OP_DIV, 32'h7FFFFFFF, 32'd3, res, lat, busy_n);
        @(negedge clk);
        dif.start_i = 1'b1;
        dif.op_i = OP_DIV;
        dif.a_i = 32'h7FFFFFFF;
        dif.b_i = 32'd3;
        @(negedge clk);
        dif.start_i = 1'b0;
        repeat (9) @(negedge clk);
        dif.kill_i = 1'b1;
        @(negedge clk);
        dif.kill_i = 1'b0;
        check("kill busy", {31'b0, dif.busy_o}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (dif.valid_o) seen++;
        end
        check("kill no valid", seen, 0);
        check("kill res held", dif.res_o, 32'h2AAAAAAA);

        dif.start_i = 1'b1;
        dif.kill_i = 1'b1;
        dif.op_i = OP_DIVU;
        dif.a_i = 32'd5;
        dif.b_i = 32'd0;
        @(negedge clk);
        dif.start_i = 1'b0;
        dif.kill_i = 1'b0;
        check("kill idle busy", {31'b0, dif.busy_o}, 32'd0);
        check("kill idle valid", {31'b0, dif.valid_o}, 32'd0);

        run_op(OP_DIVU, 32'd100, 32'd7, res, lat, busy_n);
        check("after kill res", res, 32'd14);
        check("after kill latency", lat, 34);

        // asynchronous reset mid-operation
        @(negedge clk);
        dif.start_i = 1'b1;
        dif.op_i = OP_DIV;
        dif.a_i = 32'd1000;
        dif.b_i = 32'd3;
        @(negedge clk);
        dif.start_i = 1'b0;
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst busy", {31'b0, dif.busy_o}, 32'd0);
        check("rst valid", {31'b0, dif.valid_o}, 32'd0);
        check("rst res", dif.res_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (dif.valid_o) seen++;
        end
        check("rst no valid", seen, 0);

        // back-to-back: next start presented in the valid_o cycle
        @(negedge clk);
        dif.start_i = 1'b1;
        dif.op_i = OP_DIVU;
        dif.a_i = 32'd3;
        dif.b_i = 32'd10;
        @(negedge clk);
        dif.start_i = 1'b0;
        wait_valid(res, lat, busy_n);
        check("b2b first res", res, 32'd0);
        check("b2b first latency", lat, EARLY_BUILD ? 1 : 34);
        dif.start_i = 1'b1;
        dif.op_i = OP_DIVU;
        dif.a_i = 32'd100;
        dif.b_i = 32'd7;
        @(negedge clk);
        dif.start_i = 1'b0;
        wait_valid(res, lat, busy_n);
        check("b2b second res", res, 32'd14);
        check("b2b second latency", lat, 34);

        @(negedge clk);
        check("valid/busy protocol violations", viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
